// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch over req/ack, holds each instruction until exec_done, then selects next PC
// Ports: clk/rst (async high); im_req/im_addr/im_rdata/im_ack to instruction memory;
// opcode/instr/instr_valid to control unit and datapath; pc_sel/equ/les/reg_target/exec_done
// from them; pc, halted, illegal_sel (one-cycle pulse) and retired (instruction count) as status.
module fetch_sequencer #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_rdata,
  input  logic              im_ack,
  output logic [5:0]        opcode,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic [2:0]        pc_sel,
  input  logic              equ,
  input  logic              les,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              exec_done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal_sel,
  output logic [31:0]       retired
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc_inc, pc_br, pc_n;
  logic ack_ok, retire, taken;
  assign im_addr = pc;
  always_comb begin
    pc_inc = pc + ADDR_W'(1);
    // branch offset is a signed 16-bit word offset relative to pc+1
    pc_br = pc_inc + ADDR_W'($signed(instr[15:0]));
    taken = (opcode == 6'd30 && equ) || (opcode == 6'd31 && les);
    ack_ok = state == FETCH && im_req && im_ack;
    retire = state == EXEC && exec_done;
    pc_n = pc_sel == 3'd0 ? instr[ADDR_W-1:0] :
           pc_sel == 3'd1 ? (taken ? pc_br : pc_inc) :
           pc_sel == 3'd2 ? reg_target :
           pc_sel == 3'd4 ? pc : pc_inc;
    state_n = state;
    case (state)
      FETCH:   state_n = ack_ok ? DECODE : FETCH;
      DECODE:  state_n = EXEC;
      EXEC:    state_n = !exec_done ? EXEC : pc_sel == 3'd4 ? HALT : FETCH;
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      im_req <= 1'b0;
      instr <= '0;
      opcode <= '0;
      instr_valid <= 1'b0;
      halted <= 1'b0;
      illegal_sel <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_n;
      // request is raised on the edge that enters FETCH, so it is visible in the first FETCH cycle
      im_req <= state_n == FETCH;
      instr_valid <= state_n == EXEC;
      illegal_sel <= retire && pc_sel[2] && pc_sel[1:0] != 2'd0;
      if (ack_ok) begin
        instr <= im_rdata;
        opcode <= im_rdata[31:26];
      end
      if (retire) begin
        pc <= pc_n;
        retired <= retired + 32'd1;
        halted <= pc_sel == 3'd4;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized self-checking bench for fetch_sequencer against a PC/retire model
module tb_fetch_sequencer;
  localparam int AW = 16;
  localparam int M = (1 << AW) - 1;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic im_ack = 0, equ = 0, les = 0, exec_done = 0;
  logic [31:0] im_rdata = 0;
  logic [2:0] pc_sel = 0;
  logic [AW-1:0] reg_target = 0;
  logic im_req, instr_valid, halted, illegal_sel;
  logic [AW-1:0] im_addr, pc;
  logic [5:0] opcode;
  logic [31:0] instr, retired;
  logic b_im_req, b_instr_valid, b_halted, b_illegal_sel;
  logic [AW-1:0] b_im_addr, b_pc;
  logic [5:0] b_opcode;
  logic [31:0] b_instr, b_retired;
  fetch_sequencer #(.ADDR_W(AW)) u0 (
    .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ack(im_ack),
    .opcode(opcode), .instr(instr), .instr_valid(instr_valid), .pc_sel(pc_sel), .equ(equ), .les(les),
    .reg_target(reg_target), .exec_done(exec_done), .pc(pc), .halted(halted),
    .illegal_sel(illegal_sel), .retired(retired));
  fetch_sequencer #(.ADDR_W(AW), .RESET_PC(16'hFFFF)) u1 (
    .clk(clk), .rst(rst), .im_req(b_im_req), .im_addr(b_im_addr), .im_rdata(im_rdata), .im_ack(im_ack),
    .opcode(b_opcode), .instr(b_instr), .instr_valid(b_instr_valid), .pc_sel(pc_sel), .equ(equ), .les(les),
    .reg_target(reg_target), .exec_done(exec_done), .pc(b_pc), .halted(b_halted),
    .illegal_sel(b_illegal_sel), .retired(b_retired));
  int cyc = 0;
  always @(posedge clk) cyc++;
  int tests = 0, fails = 0, start_cyc = 0;
  int unsigned mpc = 0, mret = 0;
  function automatic int unsigned mnext(int unsigned p, logic [31:0] w, int sel, bit e, bit l, int unsigned rt);
    int off, op;
    off = int'($signed(w[15:0]));
    op = int'(w[31:26]);
    if (sel == 0) return w & M;
    if (sel == 1) return ((op == 30 && e) || (op == 31 && l)) ? ((int'(p) + 1 + off) & M) : ((p + 1) & M);
    if (sel == 2) return rt & M;
    if (sel == 4) return p;
    return (p + 1) & M;
  endfunction
  task automatic do_reset;
    rst = 1; im_ack = 0; exec_done = 0; pc_sel = 0;
    repeat (2) @(negedge clk);
    rst = 0; mpc = 0; mret = 0;
  endtask
  task automatic do_instr(input logic [31:0] w, input int sel, input bit e, l, input int unsigned rt, input int aw, dw);
    int n = 0;
    while (im_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    start_cyc = cyc;
    tests++;
    if (im_req !== 1'b1 || im_addr !== AW'(mpc)) begin
      fails++; $display("FAIL fetch_addr: im_req=%b im_addr=%h, expected im_req=1 im_addr=%h", im_req, im_addr, AW'(mpc));
      return;
    end
    repeat (aw) @(negedge clk);
    im_ack = 1; im_rdata = w;
    @(negedge clk);
    im_ack = 0; im_rdata = $urandom;
    tests++;
    if (instr !== w || opcode !== w[31:26] || instr_valid !== 1'b0) begin
      fails++; $display("FAIL decode: instr=%h opcode=%0d valid=%b, expected %h %0d 0", instr, opcode, instr_valid, w, w[31:26]);
    end
    @(negedge clk);
    pc_sel = 3'(sel); equ = e; les = l; reg_target = AW'(rt);
    tests++;
    if (instr_valid !== 1'b1 || instr !== w) begin
      fails++; $display("FAIL exec_valid: valid=%b instr=%h, expected 1 %h", instr_valid, instr, w);
    end
    repeat (dw) @(negedge clk);
    tests++;
    if (instr_valid !== 1'b1 || retired !== mret) begin
      fails++; $display("FAIL exec_hold: valid=%b retired=%0d, expected 1 %0d", instr_valid, retired, mret);
    end
    exec_done = 1;
    @(negedge clk);
    exec_done = 0;
    mpc = mnext(mpc, w, sel, e, l, rt);
    mret++;
    pc_sel = 3'($urandom); equ = 1'($urandom); les = 1'($urandom); reg_target = AW'($urandom);
    tests++;
    if (pc !== AW'(mpc) || retired !== mret || instr_valid !== 1'b0 || halted !== (sel == 4) || illegal_sel !== (sel >= 5)) begin
      fails++;
      $display("FAIL retire sel=%0d: pc=%h retired=%0d valid=%b halted=%b illegal=%b, expected pc=%h retired=%0d valid=0 halted=%b illegal=%b",
               sel, pc, retired, instr_valid, halted, illegal_sel, AW'(mpc), mret, sel == 4, sel >= 5);
    end
    if (sel >= 5) begin
      @(negedge clk);
      tests++;
      if (illegal_sel !== 1'b0) begin
        fails++; $display("FAIL illegal_pulse: illegal_sel=%b, expected 0", illegal_sel);
      end
    end
  endtask
  task automatic test_reset;
    rst = 1;
    #7;
    tests++;
    if (im_req !== 0 || im_addr !== 0 || instr !== 0 || opcode !== 0 || instr_valid !== 0 || halted !== 0 ||
        illegal_sel !== 0 || retired !== 0 || b_pc !== 16'hFFFF) begin
      fails++;
      $display("FAIL reset_values: req=%b addr=%h instr=%h op=%0d valid=%b halted=%b ill=%b ret=%0d b_pc=%h, expected all 0 and b_pc=ffff",
               im_req, im_addr, instr, opcode, instr_valid, halted, illegal_sel, retired, b_pc);
    end
    @(negedge clk);
    rst = 0; im_ack = 1; im_rdata = 32'hDEAD_BEEF; mpc = 0; mret = 0;
    @(negedge clk);
    im_ack = 0;
    tests++;
    if (im_req !== 1'b1 || instr !== 0 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL ignored_ack: req=%b instr=%h valid=%b, expected 1 0 0", im_req, instr, instr_valid);
    end
  endtask
  task automatic test_sequential;
    int s[3];
    for (int i = 0; i < 3; i++) begin
      do_instr({6'd3, 26'(i)}, 3, 0, 0, 0, 0, 0);
      s[i] = start_cyc;
    end
    tests++;
    if (s[1] - s[0] != 3 || s[2] - s[1] != 3 || retired !== 32'd3) begin
      fails++; $display("FAIL latency: gaps=%0d,%0d retired=%0d, expected 3,3 retired=3", s[1] - s[0], s[2] - s[1], retired);
    end
  endtask
  task automatic test_branch;
    do_reset;
    do_instr({6'd2, 26'd5}, 0, 0, 0, 0, 1, 0);
    do_instr({6'd31, 10'd0, 16'hFFFE}, 1, 0, 1, 0, 0, 1);
    do_instr({6'd2, 26'd5}, 0, 0, 0, 0, 0, 0);
    do_instr({6'd31, 10'd0, 16'hFFFE}, 1, 1, 0, 0, 2, 0);
    do_instr({6'd30, 10'd0, 16'h0010}, 1, 1, 0, 0, 0, 0);
    do_instr({6'd3, 26'd0}, 3, 0, 0, 0, 0, 0);
  endtask
  task automatic test_jumps;
    do_instr({6'd2, 10'd0, 16'h1234}, 0, 0, 0, 0, 0, 0);
    do_instr({6'd4, 26'd0}, 2, 0, 0, 32'h00AA, 0, 0);
    do_instr({6'd3, 26'd0}, 3, 0, 0, 0, 0, 0);
  endtask
  task automatic test_wrap_illegal;
    do_reset;
    tests++;
    if (b_im_addr !== 16'hFFFF) begin
      fails++; $display("FAIL reset_pc_param: im_addr=%h, expected ffff", b_im_addr);
    end
    do_instr({6'd3, 26'd0}, 3, 0, 0, 0, 0, 0);
    tests++;
    if (b_pc !== 16'h0000 || b_retired !== 32'd1) begin
      fails++; $display("FAIL pc_wrap: pc=%h retired=%0d, expected 0000 1", b_pc, b_retired);
    end
    do_instr({6'd7, 26'd0}, 6, 0, 0, 0, 0, 0);
    tests++;
    if (b_pc !== 16'h0001) begin
      fails++; $display("FAIL illegal_advance: pc=%h, expected 0001", b_pc);
    end
  endtask
  task automatic test_random;
    int sels[8] = '{0, 1, 1, 2, 3, 5, 6, 7};
    logic [5:0] op;
    do_reset;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom % 3 == 0) ? 6'(30 + $urandom % 2) : 6'($urandom);
      do_instr({op, 26'($urandom)}, sels[$urandom % 8], 1'($urandom), 1'($urandom), $urandom % 65536,
               $urandom % 3, $urandom % 3);
    end
  endtask
  task automatic test_halt;
    do_instr({6'd63, 26'd0}, 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      im_ack = 1'($urandom); exec_done = 1'($urandom); im_rdata = $urandom;
      @(negedge clk);
      tests++;
      if (im_req !== 0 || halted !== 1 || instr_valid !== 0 || retired !== mret || pc !== AW'(mpc)) begin
        fails++;
        $display("FAIL halt_hold cycle %0d: req=%b halted=%b valid=%b retired=%0d pc=%h, expected 0 1 0 %0d %h",
                 i, im_req, halted, instr_valid, retired, pc, mret, AW'(mpc));
      end
    end
    im_ack = 0; exec_done = 0;
  endtask
  task automatic test_reset_mid_exec;
    int n = 0;
    do_reset;
    do_instr({6'd3, 26'd0}, 3, 0, 0, 0, 0, 0);
    while (im_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    im_ack = 1; im_rdata = 32'h0C00_0042;
    @(negedge clk);
    im_ack = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    tests++;
    if (instr_valid !== 0 || instr !== 0 || opcode !== 0 || pc !== 0 || retired !== 0 || im_req !== 0) begin
      fails++;
      $display("FAIL async_reset: valid=%b instr=%h op=%0d pc=%h retired=%0d req=%b, expected all 0",
               instr_valid, instr, opcode, pc, retired, im_req);
    end
    @(negedge clk);
    rst = 0; mpc = 0; mret = 0;
    repeat (2) @(negedge clk);
    exec_done = 1;
    repeat (3) @(negedge clk);
    tests++;
    if (retired !== 0 || instr_valid !== 0 || im_addr !== 0 || im_req !== 1) begin
      fails++;
      $display("FAIL stale_done: retired=%0d valid=%b addr=%h req=%b, expected 0 0 0000 1", retired, instr_valid, im_addr, im_req);
    end
    exec_done = 0;
    do_instr({6'd3, 26'd0}, 3, 0, 0, 0, 0, 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_sequential;
    test_branch;
    test_jumps;
    test_wrap_illegal;
    test_random;
    test_halt;
    test_reset_mid_exec;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and PC sequencer that drives the control unit's opcode input and consumes its PC-select result (sel[2:0]) plus the equ/les flags to pick the next PC.
- Fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Holds each instruction stable until the datapath signals completion, then retires it and fetches the next.
- Sits between instruction memory and the control unit / datapath.

Parameters:
ADDR_W, 16, PC / instruction-memory word-address width (must be <= 26)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
im_req  out  1  instruction-memory read request
im_addr  out  ADDR_W  word address of the request (= pc)
im_rdata  in  32  instruction word; valid when im_ack=1
im_ack  in  1  memory response strobe, sampled only in FETCH
opcode  out  6  instr[31:26], to control unit
instr  out  32  latched instruction word, to datapath
instr_valid  out  1  instr/opcode stable and being executed
pc_sel  in  3  control unit sel[2:0] for the current instruction
equ  in  1  datapath equal flag
les  in  1  datapath less-than flag
reg_target  in  ADDR_W  register-sourced jump target
exec_done  in  1  datapath finished current instruction
pc  out  ADDR_W  current PC
halted  out  1  sequencer stopped
illegal_sel  out  1  one-cycle pulse: pc_sel was 5, 6 or 7 at retire
retired  out  32  count of retired instructions

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, im_req=0, im_addr=RESET_PC, instr=0, opcode=0, instr_valid=0, halted=0, illegal_sel=0, retired=0. Any in-flight fetch is abandoned.
- All outputs are registered.
- FSM states: FETCH, DECODE, EXEC, HALT.
- FETCH:
  - im_req=1 and im_addr=pc from the first cycle after entry.
  - On a clock edge with im_req=1 and im_ack=1: latch instr<=im_rdata, opcode<=im_rdata[31:26], drop im_req, go to DECODE.
  - An ack while im_req=0 (first cycle after reset) is ignored.
- DECODE:
  - Exactly 1 cycle, so the clocked control unit can register sel from opcode.
  - Go to EXEC and set instr_valid=1.
- EXEC:
  - Hold instr/opcode/instr_valid stable until exec_done=1. exec_done seen in the first EXEC cycle is accepted.
  - On exec_done: instr_valid<=0 and retired<=retired+1 (wraps at 2^32). Compute next PC from pc_sel, then go to FETCH, or to HALT for pc_sel 4.
  - pc_sel 0: pc <= instr[ADDR_W-1:0] (absolute jump).
  - pc_sel 1: take the branch if (opcode==30 and equ) or (opcode==31 and les). Taken: pc <= pc+1+sign_extend(instr[15:0]) truncated to ADDR_W. Not taken: pc+1.
  - pc_sel 2: pc <= reg_target.
  - pc_sel 3: pc <= pc+1.
  - pc_sel 4: pc unchanged, halted<=1, go to HALT.
  - pc_sel 5/6/7: pc <= pc+1, illegal_sel pulses high for 1 cycle.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W; pc+1 at max address wraps to 0.
- HALT: absorbing. im_req=0, instr_valid=0, all inputs ignored; only rst exits.
- Latency: minimum 3 cycles per instruction (FETCH with same-cycle ack, DECODE, EXEC with immediate exec_done).
- Inputs pc_sel, equ, les and reg_target are sampled only on the exec_done edge.

Test Plan:
- Reset, memory acks in the 2nd FETCH cycle, words with opcode 3 at addresses 0..2, exec_done immediate -> im_addr sequence 0,1,2; retired=3; each instruction takes 3 cycles after im_req rises.
- Instruction opcode 31, offset 0xFFFE at pc=5, pc_sel=1, les=1 -> next im_addr=4. Same with les=0 -> 6.
- pc_sel=0 with instr[15:0]=0x1234 -> im_addr=0x1234. pc_sel=2 with reg_target=0x00AA -> im_addr=0x00AA.
- RESET_PC=0xFFFF, pc_sel=3 -> next pc wraps to 0x0000. pc_sel=6 -> illegal_sel high exactly 1 cycle and pc advances by 1.
- pc_sel=4 -> halted=1; im_req stays 0 for 20 cycles despite im_ack/exec_done toggling; retired unchanged.
- rst asserted mid-EXEC, with exec_done delayed 5 cycles -> outputs return to reset values immediately; fetch restarts at RESET_PC; the stale exec_done does not increment retired.
